// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Bundles the completion inputs from the ALU and the LSB, their back-pressure
//   flags, and the registered common-data-bus packet.
//   master : execution-unit / consumer side (drives results, observes CDB)
//   slave  : the arbiter (takes results, drives full flags and CDB)
//   Signals:
//     alu_flag/reorder/val/opcode  ALU completion packet
//     lsb_flag/reorder/val/opcode  LSB completion packet
//     alu_full, lsb_full           per-source FIFO full
//     cdb_flag/reorder/val/opcode  granted CDB packet, cdb_src 0=ALU 1=LSB
interface cdb_arbiter_if #(
  parameter int RB_W   = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
);
  logic              alu_flag;
  logic [RB_W-1:0]   alu_reorder;
  logic [DATA_W-1:0] alu_val;
  logic [OP_W-1:0]   alu_opcode;
  logic              lsb_flag;
  logic [RB_W-1:0]   lsb_reorder;
  logic [DATA_W-1:0] lsb_val;
  logic [OP_W-1:0]   lsb_opcode;
  logic              alu_full;
  logic              lsb_full;
  logic              cdb_flag;
  logic [RB_W-1:0]   cdb_reorder;
  logic [DATA_W-1:0] cdb_val;
  logic [OP_W-1:0]   cdb_opcode;
  logic              cdb_src;

  modport master (
    output alu_flag, alu_reorder, alu_val, alu_opcode,
    output lsb_flag, lsb_reorder, lsb_val, lsb_opcode,
    input  alu_full, lsb_full,
    input  cdb_flag, cdb_reorder, cdb_val, cdb_opcode, cdb_src
  );

  modport slave (
    input  alu_flag, alu_reorder, alu_val, alu_opcode,
    input  lsb_flag, lsb_reorder, lsb_val, lsb_opcode,
    output alu_full, lsb_full,
    output cdb_flag, cdb_reorder, cdb_val, cdb_opcode, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus write-back arbiter. ALU and LSB results are each buffered
//   in a 2**ADDR_W-deep FIFO; one head entry per cycle is granted round-robin
//   onto the registered CDB port.
//   Optional feature: define CDB_BYPASS_EN to let a result arriving at an
//   empty FIFO compete for the bus in the same cycle without being buffered.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     rdy  global ready, low freezes every register
//     clr  synchronous flush of all buffered and incoming results
//     bus  cdb_arbiter_if.slave (completion inputs, full flags, CDB outputs)
module cdb_arbiter #(
  parameter int RB_W   = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  cdb_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int ENT_W = RB_W + DATA_W + OP_W;

  // Index 0 = ALU, index 1 = LSB.
  logic [1:0]       in_flag;
  logic [ENT_W-1:0] in_ent   [2];
  logic [ENT_W-1:0] head_ent [2];
  logic [ENT_W-1:0] sel_ent  [2];
  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       byp;
  logic [1:0]       cand;
  logic [1:0]       take;
  logic [1:0]       push;
  logic [1:0]       pop;

  logic             active;
  logic             grant;
  logic             win;

  logic             cdb_flag_reg;
  logic [RB_W-1:0]  cdb_reorder_reg;
  logic [DATA_W-1:0] cdb_val_reg;
  logic [OP_W-1:0]  cdb_opcode_reg;
  logic             cdb_src_reg;
  logic             last_reg;

  assign in_flag[0] = bus.alu_flag;
  assign in_flag[1] = bus.lsb_flag;
  assign in_ent[0]  = {bus.alu_reorder, bus.alu_val, bus.alu_opcode};
  assign in_ent[1]  = {bus.lsb_reorder, bus.lsb_val, bus.lsb_opcode};

  assign active = rdy && !clr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ENT_W-1:0]  mem [DEPTH];
      logic [ADDR_W-1:0] head_reg;
      logic [ADDR_W-1:0] tail_reg;
      logic [ADDR_W:0]   count_reg;

      assign full[gi]     = (count_reg == (ADDR_W+1)'(DEPTH));
      assign nonempty[gi] = (count_reg != '0);
      assign head_ent[gi] = mem[head_reg];

`ifdef CDB_BYPASS_EN
      // An incoming result at an empty FIFO competes directly for the bus.
      assign byp[gi] = in_flag[gi] && !nonempty[gi];
`else
      assign byp[gi] = 1'b0;
`endif

      assign cand[gi]    = nonempty[gi] || byp[gi];
      // Buffered entries always take priority over the live input.
      assign sel_ent[gi] = nonempty[gi] ? head_ent[gi] : in_ent[gi];
      assign take[gi]    = grant && (win == 1'(gi));
      assign pop[gi]     = take[gi] && nonempty[gi];
      // A bypassed winner goes straight to the CDB and must not also be queued.
      assign push[gi]    = in_flag[gi] && !full[gi] && active &&
                           !(take[gi] && !nonempty[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
        end else if (rdy) begin
          if (clr) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
          end else begin
            if (push[gi]) tail_reg <= tail_reg + ADDR_W'(1);
            if (pop[gi])  head_reg <= head_reg + ADDR_W'(1);
            count_reg <= count_reg + (ADDR_W+1)'(push[gi]) - (ADDR_W+1)'(pop[gi]);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem[tail_reg] <= in_ent[gi];
      end
    end
  endgenerate

  // Round-robin: a tie goes to the source that did not win last time.
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (active && (cand != 2'b00)) begin
      grant = 1'b1;
      if (cand == 2'b11) win = ~last_reg;
      else               win = cand[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_flag_reg    <= 1'b0;
      cdb_reorder_reg <= '0;
      cdb_val_reg     <= '0;
      cdb_opcode_reg  <= '0;
      cdb_src_reg     <= 1'b0;
      last_reg        <= 1'b1;  // ALU wins the first tie
    end else if (rdy) begin
      if (clr) begin
        cdb_flag_reg <= 1'b0;
      end else if (grant) begin
        cdb_flag_reg <= 1'b1;
        {cdb_reorder_reg, cdb_val_reg, cdb_opcode_reg} <= win ? sel_ent[1] : sel_ent[0];
        cdb_src_reg  <= win;
        last_reg     <= win;
      end else begin
        cdb_flag_reg <= 1'b0;
      end
    end
  end

  assign bus.alu_full    = full[0];
  assign bus.lsb_full    = full[1];
  assign bus.cdb_flag    = cdb_flag_reg;
  assign bus.cdb_reorder = cdb_reorder_reg;
  assign bus.cdb_val     = cdb_val_reg;
  assign bus.cdb_opcode  = cdb_opcode_reg;
  assign bus.cdb_src     = cdb_src_reg;
endmodule
